// File: rtl/hazard_sequencer.sv
// Decode-stage hazard controller: forwarding, load-use bubbles, LDW/SDW micro-op sequencing, branch squash.
// Optional macro HZD_FWD_EN enables forwarding; without it every in-flight match stalls.
module hazard_sequencer #(
   parameter logic [5:0] OP_LW  = 6'd10,
   parameter logic [5:0] OP_LDW = 6'd11,
   parameter logic [5:0] OP_SDW = 6'd13
) (
   input  logic        clk,
   input  logic        clear,
   input  logic [5:0]  op_code,
   input  logic [3:0]  rs,
   input  logic [3:0]  rb,
   input  logic        rs_used,
   input  logic        rb_used,
   input  logic [3:0]  ex_rd,
   input  logic [3:0]  mem_rd,
   input  logic [3:0]  wb_rd,
   input  logic        ex_reg_w,
   input  logic        mem_reg_w,
   input  logic        wb_reg_w,
   input  logic        ex_mem_r,
   input  logic        kill,
   output logic        stall,
   output logic        bubble,
   output logic        turn_off,
   output logic        add_rd,
   output logic        add_imm,
   output logic [1:0]  fwa,
   output logic [1:0]  fwb,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {NORM, DW2, KILL} state_t;

   state_t     state, state_nxt;
   logic       ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;
   logic       hazard;
   logic       is_dw;
   logic [1:0] fwa_raw, fwb_raw;

   // Loads are flagged upstream through ex_mem_r; OP_LW is kept for interface compatibility.
   logic       unused_op_lw;
   assign unused_op_lw = ^OP_LW;

   function automatic logic [1:0] fw_pick(input logic e, input logic m, input logic w);
      if (e)      return 2'b01;
      else if (m) return 2'b10;
      else if (w) return 2'b11;
      else        return 2'b00;
   endfunction

   assign ex_a  = ex_reg_w  && (ex_rd  == rs) && rs_used;
   assign mem_a = mem_reg_w && (mem_rd == rs) && rs_used;
   assign wb_a  = wb_reg_w  && (wb_rd  == rs) && rs_used;
   assign ex_b  = ex_reg_w  && (ex_rd  == rb) && rb_used;
   assign mem_b = mem_reg_w && (mem_rd == rb) && rb_used;
   assign wb_b  = wb_reg_w  && (wb_rd  == rb) && rb_used;

`ifdef HZD_FWD_EN
   assign hazard  = ex_mem_r && (ex_a || ex_b);
   assign fwa_raw = fw_pick(ex_a, mem_a, wb_a);
   assign fwb_raw = fw_pick(ex_b, mem_b, wb_b);
`else
   logic unused_ex_mem_r;
   assign unused_ex_mem_r = ex_mem_r;
   assign hazard  = ex_a || mem_a || wb_a || ex_b || mem_b || wb_b;
   assign fwa_raw = '0;
   assign fwb_raw = '0;
`endif

   assign is_dw = (op_code == OP_LDW) || (op_code == OP_SDW);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) state <= NORM;
      else        state <= state_nxt;
   end

   assign turn_off = (state == KILL);
   assign add_rd   = (state == DW2);
   assign add_imm  = (state == DW2);

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bubble    = 1'b0;
      fwa       = '0;
      fwb       = '0;
      if (clear) begin
         unique case (state)
            NORM: begin
               fwa = fwa_raw;
               fwb = fwb_raw;
               // A hazard stall outranks both DW issue and a kill; the branch re-resolves next cycle.
               if (hazard) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end else if (is_dw) begin
                  stall     = 1'b1;
                  state_nxt = DW2;
               end else if (kill) begin
                  state_nxt = KILL;
               end
            end
            DW2: begin
               fwa = fwa_raw;
               fwb = fwb_raw;
               if (hazard) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end else begin
                  state_nxt = NORM;
               end
            end
            KILL: state_nxt = NORM;
            default: state_nxt = NORM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear)                          stall_cnt <= '0;
      else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer; expectations adapt to whether HZD_FWD_EN is defined.
module tb_hazard_sequencer;

`ifdef HZD_FWD_EN
   localparam bit F = 1'b1;
`else
   localparam bit F = 1'b0;
`endif

   typedef struct packed {
      logic       clear;
      logic [5:0] op;
      logic [3:0] rs, rb, ex_rd, mem_rd, wb_rd;
      logic       rs_used, rb_used, ex_w, mem_w, wb_w, ex_mem_r, kill;
   } in_t;

   typedef struct packed {
      logic        stall, bubble, turn_off, add_rd, add_imm;
      logic [1:0]  fwa, fwb;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic [5:0]  op_code = '0;
   logic [3:0]  rs = '0, rb = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
   logic        rs_used = 1'b0, rb_used = 1'b0;
   logic        ex_reg_w = 1'b0, mem_reg_w = 1'b0, wb_reg_w = 1'b0;
   logic        ex_mem_r = 1'b0, kill = 1'b0;
   logic        stall, bubble, turn_off, add_rd, add_imm;
   logic [1:0]  fwa, fwb;
   logic [15:0] stall_cnt;

   exp_t        sb[$];
   exp_t        m_e;
   logic [15:0] exp_cnt = '0;
   int          checks = 0;
   int          errors = 0;
   in_t         v;

   always #5 clk = ~clk;

   hazard_sequencer #(.OP_LW(6'd10), .OP_LDW(6'd11), .OP_SDW(6'd13)) dut (
      .clk(clk), .clear(clear), .op_code(op_code), .rs(rs), .rb(rb),
      .rs_used(rs_used), .rb_used(rb_used), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_reg_w(ex_reg_w), .mem_reg_w(mem_reg_w), .wb_reg_w(wb_reg_w),
      .ex_mem_r(ex_mem_r), .kill(kill), .stall(stall), .bubble(bubble),
      .turn_off(turn_off), .add_rd(add_rd), .add_imm(add_imm),
      .fwa(fwa), .fwb(fwb), .stall_cnt(stall_cnt)
   );

   function automatic in_t idle();
      in_t t;
      t = '0;
      t.clear = 1'b1;
      return t;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and queue the outputs expected at this cycle's negedge.
   task automatic step(input in_t t, input logic st, input logic bu, input logic to,
                       input logic ad, input logic [1:0] a, input logic [1:0] b);
      exp_t e;
      @(posedge clk);
      #1;
      clear = t.clear; op_code = t.op; rs = t.rs; rb = t.rb;
      ex_rd = t.ex_rd; mem_rd = t.mem_rd; wb_rd = t.wb_rd;
      rs_used = t.rs_used; rb_used = t.rb_used;
      ex_reg_w = t.ex_w; mem_reg_w = t.mem_w; wb_reg_w = t.wb_w;
      ex_mem_r = t.ex_mem_r; kill = t.kill;
      if (!t.clear) exp_cnt = '0;
      e.stall = st; e.bubble = bu; e.turn_off = to; e.add_rd = ad; e.add_imm = ad;
      e.fwa = a; e.fwb = b; e.cnt = exp_cnt;
      sb.push_back(e);
      if (t.clear && st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         m_e = sb.pop_front();
         chk("stall",     {15'd0, stall},    {15'd0, m_e.stall});
         chk("bubble",    {15'd0, bubble},   {15'd0, m_e.bubble});
         chk("turn_off",  {15'd0, turn_off}, {15'd0, m_e.turn_off});
         chk("add_rd",    {15'd0, add_rd},   {15'd0, m_e.add_rd});
         chk("add_imm",   {15'd0, add_imm},  {15'd0, m_e.add_imm});
         chk("fwa",       {14'd0, fwa},      {14'd0, m_e.fwa});
         chk("fwb",       {14'd0, fwb},      {14'd0, m_e.fwb});
         chk("stall_cnt", stall_cnt,         m_e.cnt);
      end
   end

   initial begin
      // reset with busy inputs
      v = idle(); v.clear = 1'b0; v.op = 6'd11; v.rs = 4'd3; v.rs_used = 1'b1;
      v.ex_rd = 4'd3; v.ex_w = 1'b1; v.ex_mem_r = 1'b1; v.kill = 1'b1;
      step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v = idle(); step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      // forwarding priority on rs
      v = idle(); v.rs = 4'd3; v.rs_used = 1'b1;
      v.ex_rd = 4'd3; v.mem_rd = 4'd3; v.wb_rd = 4'd3; v.ex_w = 1'b1; v.mem_w = 1'b1; v.wb_w = 1'b1;
      step(v, !F, !F, 0, 0, F ? 2'd1 : 2'd0, 2'd0);
      v.ex_w = 1'b0;  step(v, !F, !F, 0, 0, F ? 2'd2 : 2'd0, 2'd0);
      v.mem_w = 1'b0; step(v, !F, !F, 0, 0, F ? 2'd3 : 2'd0, 2'd0);
      v.wb_w = 1'b0;  step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v.ex_w = 1'b1; v.rs_used = 1'b0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      // rb forwarding, register 0 matching
      v = idle(); v.rb = 4'd7; v.rb_used = 1'b1; v.rs = 4'd7;
      v.ex_rd = 4'd7; v.ex_w = 1'b1; v.mem_rd = 4'd7; v.mem_w = 1'b1;
      step(v, !F, !F, 0, 0, 2'd0, F ? 2'd1 : 2'd0);
      v = idle(); v.rs_used = 1'b1; v.wb_w = 1'b1;
      step(v, !F, !F, 0, 0, F ? 2'd3 : 2'd0, 2'd0);

      // load-use on rb then MEM forward
      v = idle(); v.ex_mem_r = 1'b1; v.ex_rd = 4'd5; v.ex_w = 1'b1; v.rb = 4'd5; v.rb_used = 1'b1;
      step(v, 1, 1, 0, 0, 2'd0, F ? 2'd1 : 2'd0);
      v = idle(); v.rb = 4'd5; v.rb_used = 1'b1; v.mem_rd = 4'd5; v.mem_w = 1'b1;
      step(v, !F, !F, 0, 0, 2'd0, F ? 2'd2 : 2'd0);

      // MEM match held for three cycles
      v = idle(); v.rs = 4'd2; v.rs_used = 1'b1; v.mem_rd = 4'd2; v.mem_w = 1'b1;
      repeat (3) step(v, !F, !F, 0, 0, F ? 2'd2 : 2'd0, 2'd0);
      v.mem_w = 1'b0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      // LDW and SDW sequencing
      v = idle(); v.op = 6'd11;
      step(v, 1, 0, 0, 0, 2'd0, 2'd0);
      step(v, 0, 0, 0, 1, 2'd0, 2'd0);
      v.op = 6'd0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v.op = 6'd13;
      step(v, 1, 0, 0, 0, 2'd0, 2'd0);
      step(v, 0, 0, 0, 1, 2'd0, 2'd0);
      v.op = 6'd0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      // kill, repeated kill, suppression in KILL
      v = idle(); v.kill = 1'b1; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v.kill = 1'b0; step(v, 0, 0, 1, 0, 2'd0, 2'd0);
      step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v.kill = 1'b1; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      step(v, 0, 0, 1, 0, 2'd0, 2'd0);
      v.kill = 1'b0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v.kill = 1'b1; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v = idle(); v.op = 6'd11; v.ex_mem_r = 1'b1; v.ex_rd = 4'd4; v.ex_w = 1'b1;
      v.rs = 4'd4; v.rs_used = 1'b1;
      step(v, 0, 0, 1, 0, 2'd0, 2'd0);
      v = idle(); step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      // kill during load-use is dropped; kill during DW issue is dropped
      v = idle(); v.ex_mem_r = 1'b1; v.ex_rd = 4'd5; v.ex_w = 1'b1; v.rb = 4'd5; v.rb_used = 1'b1;
      v.kill = 1'b1; step(v, 1, 1, 0, 0, 2'd0, F ? 2'd1 : 2'd0);
      v = idle(); step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v = idle(); v.op = 6'd11; v.kill = 1'b1; step(v, 1, 0, 0, 0, 2'd0, 2'd0);
      v.kill = 1'b0; step(v, 0, 0, 0, 1, 2'd0, 2'd0);
      v.op = 6'd0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      // LDW with load-use stalls in NORM and in DW2
      v = idle(); v.op = 6'd11; v.rs = 4'd6; v.rs_used = 1'b1; v.ex_rd = 4'd6; v.ex_w = 1'b1;
      v.ex_mem_r = 1'b1; step(v, 1, 1, 0, 0, F ? 2'd1 : 2'd0, 2'd0);
      v.ex_w = 1'b0; v.ex_mem_r = 1'b0; step(v, 1, 0, 0, 0, 2'd0, 2'd0);
      v.ex_w = 1'b1; v.ex_mem_r = 1'b1; step(v, 1, 1, 0, 1, F ? 2'd1 : 2'd0, 2'd0);
      v.ex_w = 1'b0; v.ex_mem_r = 1'b0; step(v, 0, 0, 0, 1, 2'd0, 2'd0);
      v = idle(); step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      // reset mid-DW2 and mid-KILL
      v = idle(); v.op = 6'd11; step(v, 1, 0, 0, 0, 2'd0, 2'd0);
      v.clear = 1'b0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v = idle(); step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v = idle(); v.kill = 1'b1; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v.clear = 1'b0; v.kill = 1'b0; step(v, 0, 0, 0, 0, 2'd0, 2'd0);
      v = idle(); step(v, 0, 0, 0, 0, 2'd0, 2'd0);

      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
